// File: rtl/target_coord_gen_pkg.sv
// target_coord_gen_pkg: shared LFSR constants and helpers for the coordinate generator.
//   LFSR_W        : LFSR width (24)
//   LFSR_TAPS     : feedback mask for taps 24,23,22,17 (bit positions 23,22,21,16)
//   ZERO_SEED_SUB : value substituted for an all-zero seed (zero would lock the LFSR)
package target_coord_gen_pkg;
  localparam int LFSR_W = 24;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000;
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 24'h000001;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? ZERO_SEED_SUB : s;
  endfunction
endpackage

// File: rtl/target_coord_gen_fifo.sv
// coord_fifo: DEPTH-entry first-in-first-out buffer with flush, zeroed head when empty.
//   clk, rst_n (async active-low), flush_i (clears occupancy, has priority),
//   push_i/din_i (write, honoured when not full or when popping the same cycle),
//   pop_i (ignored when empty), dout_o (head entry, 0 when empty), full_o, empty_o, count_o.
module coord_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign do_pop = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  assign dout_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/target_coord_gen.sv
// target_coord_gen: LFSR-driven random (x,y,id) target generator feeding a prefetch FIFO.
//   clk, reset (async active-low), seed_ld/seed_in (reseed LFSR and flush FIFO),
//   out_ready (consumer takes head), out_valid/out_x/out_y/out_id (FIFO head), count (occupancy).
//   Optional macro TARGET_COORD_GEN_SPACING_EN: reject candidates closer than MIN_DIST
//   (Manhattan) to the last accepted coordinate.
module target_coord_gen
  import target_coord_gen_pkg::*;
#(
  parameter int               X_W      = 9,
  parameter int               Y_W      = 8,
  parameter int               X_MAX    = 304,
  parameter int               Y_MAX    = 214,
  parameter int               ID_W     = 2,
  parameter int               DEPTH    = 4,
  parameter logic [LFSR_W-1:0] SEED    = 24'h00ACE1,
  parameter int               MIN_DIST = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seed_ld,
  input  logic [LFSR_W-1:0]          seed_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [X_W-1:0]             out_x,
  output logic [Y_W-1:0]             out_y,
  output logic [ID_W-1:0]            out_id,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int EW = X_W + Y_W + ID_W;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic [ID_W-1:0] cand_id;
  logic [EW-1:0] head;
  logic in_range, spaced, full, empty, pop, accept;
  assign cand_x = lfsr_q[X_W-1:0];
  assign cand_y = lfsr_q[X_W+Y_W-1:X_W];
  assign cand_id = lfsr_q[LFSR_W-1 -: ID_W];
  assign in_range = (int'(cand_x) <= X_MAX) && (int'(cand_y) <= Y_MAX);
  assign pop = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept = !seed_ld && in_range && spaced && (!full || pop);
  assign lfsr_d = seed_ld ? fix_seed(seed_in) : lfsr_next(lfsr_q);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= fix_seed(SEED);
    else lfsr_q <= lfsr_d;
  end
`ifdef TARGET_COORD_GEN_SPACING_EN
  logic [X_W-1:0] last_x_q, dx;
  logic [Y_W-1:0] last_y_q, dy;
  assign dx = (cand_x >= last_x_q) ? cand_x - last_x_q : last_x_q - cand_x;
  assign dy = (cand_y >= last_y_q) ? cand_y - last_y_q : last_y_q - cand_y;
  assign spaced = (int'(dx) + int'(dy)) >= MIN_DIST;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_x_q <= '0;
      last_y_q <= '0;
    end else if (seed_ld) begin
      last_x_q <= '0;
      last_y_q <= '0;
    end else if (accept) begin
      last_x_q <= cand_x;
      last_y_q <= cand_y;
    end
  end
`else
  assign spaced = 1'b1;
`endif
  coord_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (seed_ld),
    .push_i  (accept),
    .pop_i   (out_ready),
    .din_i   ({cand_x, cand_y, cand_id}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign out_valid = !empty;
  assign {out_x, out_y, out_id} = head;
endmodule
